regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
// - Parametrised multi-port integer register file for the multi-cycle RISC-V core.
// - NRD combinational read ports and 2 write ports with priority arbitration.
// - Optional write-to-read bypass; optional hardwired-zero register 0.
// - Built-in clear sequencer zeroes every register after reset; core stalls on init_busy.
// PARAMETERS
// - XLEN      32                   data width per register
// - NREGS     32                   number of architectural registers (>=2, need not be 2^n)
// - AW        $clog2(NREGS)        address width (derived, do not override)
// - NRD       2                    number of read ports (1..4)
// - BYPASS    1                    1: same-cycle write data forwarded to read ports
// - ZERO_REG  1                    1: reg 0 reads 0, writes to it dropped
// PORTS
// - clk         in   1          clock; all state on rising edge
// - rst         in   1          synchronous reset, active-high
// - rd_addr     in   NRD*AW     read addresses, port i at [i*AW +: AW]
// - rd_data     out  NRD*XLEN   read data, port i at [i*XLEN +: XLEN]
// - wr0_en      in   1          write port 0 enable (low priority)
// - wr0_addr    in   AW         write port 0 address
// - wr0_data    in   XLEN       write port 0 data
// - wr1_en      in   1          write port 1 enable (high priority)
// - wr1_addr    in   AW         write port 1 address
// - wr1_data    in   XLEN       write port 1 data
// - init_busy   out  1          1 while clear sequence runs; writes ignored
// - wr_conflict out  1          registered 1-cycle pulse: both ports hit same reg
// BEHAVIOUR
// - FSM states ST_INIT, ST_READY; rst=1 forces ST_INIT, clr_ptr=0, wr_conflict=0.
// - ST_INIT:
//   - each cycle regs[clr_ptr] <= 0, clr_ptr++.
//   - At clr_ptr==NREGS-1 the next state is ST_READY.
//   - Clear takes exactly NREGS cycles after rst deasserts.
// - init_busy = (state==ST_INIT), combinational from state; 1 during and after rst.
// - In ST_INIT: wr0/wr1 ignored, rd_data all 0, wr_conflict stays 0.
// - rst mid-INIT restarts clr_ptr at 0.
// - rst in ST_READY re-runs the full clear.
// - Writes (ST_READY only) land on the rising edge; visible to plain reads next cycle.
// - wrN effective = wrN_en && addr<NREGS && !(ZERO_REG && addr==0).
// - Both effective, same addr: wr1_data written, wr0 dropped, wr_conflict=1 next cycle.
// - Both effective, different addrs: both written in the same cycle.
// - Read port i, combinational, zero latency, first match wins:
//   1. addr>=NREGS -> 0
//   2. ZERO_REG && addr==0 -> 0
//   3. BYPASS && wr1 effective && wr1_addr==addr -> wr1_data
//   4. BYPASS && wr0 effective && wr0_addr==addr -> wr0_data
//   5. otherwise regs[addr]
// - BYPASS=0: reads always return stored value; new data visible the cycle after the write.
// - ZERO_REG=0: reg 0 is an ordinary register (cleared by INIT, writable).
// - No X on rd_data at any time after the first rst cycle.
// STRUCTURE
// - Package regfile_pkg:
//   - typedef enum logic {ST_INIT, ST_READY} rf_state_e
//   - RF_XLEN_DEF=32, RF_NREGS_DEF=32 constants
// - Sub-module regfile_rd_port (one read mux + bypass compare), generate-instanced NRD times.
// - Storage: flop array logic [XLEN-1:0] regs [NREGS]; single always_ff for writes and clear.
// TESTING
// - rst 1 cycle, release -> init_busy=1 for exactly 32 cycles.
//   - Then 0; all 32 regs read 0.
//   - wr1 attempts during INIT have no effect.
// - READY: wr0 x5<=0xDEAD_BEEF, rd_addr0=5 same cycle.
//   - BYPASS=1: rd_data0=0xDEADBEEF same cycle.
//   - BYPASS=0: old value same cycle, 0xDEADBEEF next cycle.
// - wr0 x7<=0x1111, wr1 x7<=0x2222 together.
//   - x7=0x2222 next cycle.
//   - wr_conflict=1 for exactly 1 cycle.
// - wr1 x0<=0xFFFF_FFFF, ZERO_REG=1 -> x0 reads 0 same and next cycle; wr_conflict=0.
// - NREGS=24, wr0 addr 30 <= 0x55 -> ignored.
//   - Read addr 30 = 0.
//   - Regs 0..23 unchanged.
// - Write x3=0xA5, assert rst at INIT cycle 10, release.
//   - init_busy lasts 32 more cycles.
//   - x3 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
//   rf_state_e   : FSM state (clear sequence running / normal operation)
//   RF_XLEN_DEF  : default register width
//   RF_NREGS_DEF : default number of architectural registers
package regfile_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } rf_state_e;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port of the register file: out-of-range and
// hardwired-zero filtering followed by the optional write-to-read bypass.
//   rd_addr_i   : read address
//   stored_i    : value currently held in the addressed register
//   ready_i     : 1 when the clear sequence is finished (reads return 0 before)
//   wrN_eff_i   : write port N will really write this cycle
//   wrN_addr_i  : write port N address
//   wrN_data_i  : write port N data
//   rd_data_o   : read result
module regfile_rd_port #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0] stored_i,
    input  logic            ready_i,
    input  logic            wr0_eff_i,
    input  logic [AW-1:0]   wr0_addr_i,
    input  logic [XLEN-1:0] wr0_data_i,
    input  logic            wr1_eff_i,
    input  logic [AW-1:0]   wr1_addr_i,
    input  logic [XLEN-1:0] wr1_data_i,
    output logic [XLEN-1:0] rd_data_o
);

    // Priority chain; wr1 is checked before wr0 so the forwarded value
    // matches what the storage will hold after a same-address collision.
    always_comb begin
        rd_data_o = '0;
        if (!ready_i) begin
            rd_data_o = '0;
        end else if (32'(rd_addr_i) >= NREGS) begin
            rd_data_o = '0;
        end else if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            rd_data_o = '0;
        end else if ((BYPASS != 0) && wr1_eff_i && (wr1_addr_i == rd_addr_i)) begin
            rd_data_o = wr1_data_i;
        end else if ((BYPASS != 0) && wr0_eff_i && (wr0_addr_i == rd_addr_i)) begin
            rd_data_o = wr0_data_i;
        end else begin
            rd_data_o = stored_i;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with two prioritised write
// ports, NRD combinational read ports and a clear sequencer that zeroes every
// register after reset.
//   clk, rst     : clock, synchronous active-high reset
//   rd_addr      : NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data      : NRD packed read results, port i at [i*XLEN +: XLEN]
//   wr0_*        : low-priority write port
//   wr1_*        : high-priority write port
//   init_busy    : clear sequence running, writes ignored
//   wr_conflict  : registered pulse, both ports wrote the same register
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    output logic                init_busy,
    output logic                wr_conflict
);

    rf_state_e       state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic            wr_conflict_q, wr_conflict_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic ready;
    logic wr0_eff, wr1_eff, wr0_land;

    assign ready = (state_q == ST_READY);

    // A write is only real in READY, in range, and not aimed at a hardwired x0.
    assign wr0_eff = ready && wr0_en && (32'(wr0_addr) < NREGS) &&
                     !((ZERO_REG != 0) && (wr0_addr == '0));
    assign wr1_eff = ready && wr1_en && (32'(wr1_addr) < NREGS) &&
                     !((ZERO_REG != 0) && (wr1_addr == '0));

    assign wr_conflict_d = wr0_eff && wr1_eff && (wr0_addr == wr1_addr);
    assign wr0_land      = wr0_eff && !wr_conflict_d;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_INIT) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(NREGS - 1)) begin
                state_d   = ST_READY;
                clr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_INIT;
            clr_ptr_q     <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_ptr_q     <= clr_ptr_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Storage has no reset of its own; the clear sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                regs_q[clr_ptr_q] <= '0;
            end else begin
                if (wr0_land) regs_q[wr0_addr] <= wr0_data;
                if (wr1_eff)  regs_q[wr1_addr] <= wr1_data;
            end
        end
    end

    assign init_busy   = (state_q == ST_INIT);
    assign wr_conflict = wr_conflict_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] stored;

        assign addr = rd_addr[i*AW +: AW];

        // Guard the array index so non-power-of-two sizes never read past the end.
        always_comb begin
            stored = '0;
            if (32'(addr) < NREGS) stored = regs_q[addr];
        end

        regfile_rd_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .AW       (AW),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rd_addr_i  (addr),
            .stored_i   (stored),
            .ready_i    (ready),
            .wr0_eff_i  (wr0_eff),
            .wr0_addr_i (wr0_addr),
            .wr0_data_i (wr0_data),
            .wr1_eff_i  (wr1_eff),
            .wr1_addr_i (wr1_addr),
            .wr1_data_i (wr1_data),
            .rd_data_o  (rd_data[i*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances share one stimulus stream
//   dut_a : NREGS=32, BYPASS=1, ZERO_REG=1
//   dut_b : NREGS=32, BYPASS=0, ZERO_REG=0
//   dut_c : NREGS=24, BYPASS=1, ZERO_REG=1
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  rd_addr;
    logic        wr0_en, wr1_en;
    logic [4:0]  wr0_addr, wr1_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [63:0] rd_a, rd_b, rd_c;
    logic        busy_a, busy_b, busy_c;
    logic        conf_a, conf_b, conf_c;

    int tests = 0;
    int fails = 0;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .init_busy(busy_a), .wr_conflict(conf_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .init_busy(busy_b), .wr_conflict(conf_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .BYPASS(1), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_c),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .init_busy(busy_c), .wr_conflict(conf_c)
    );

    typedef struct {
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] eb0;
        logic [31:0] eb1;
        logic        eca;
        logic        ecb;
    } vec_t;

    localparam int NV = 12;
    vec_t v [NV];
    vec_t sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en   = 1'b0; wr0_addr = 5'd0; wr0_data = 32'h0;
        wr1_en   = 1'b0; wr1_addr = 5'd0; wr1_data = 32'h0;
    endtask

    // Called at a drive point right after rst is released; counts busy cycles
    // per instance. With poke set, wr1 hammers x9 for the first 10 cycles and
    // the reads of x9 must stay 0.
    task automatic wait_init(input bit poke, output int na, output int nb, output int nc);
        bit done;
        done = 1'b0;
        na = 0; nb = 0; nc = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (poke) begin
                wr1_en   = (k < 10);
                wr1_addr = 5'd9;
                wr1_data = 32'h77;
                rd_addr  = {5'd9, 5'd9};
            end
            #4;
            if (busy_a) na++;
            if (busy_b) nb++;
            if (busy_c) nc++;
            chk("init_conf_a", 32'(conf_a), 32'h0);
            chk("init_conf_b", 32'(conf_b), 32'h0);
            chk("init_conf_c", 32'(conf_c), 32'h0);
            if (poke && k < 10) begin
                chk("init_rd_a", rd_a[31:0], 32'h0);
                chk("init_rd_b", rd_b[31:0], 32'h0);
                chk("init_rd_c", rd_c[31:0], 32'h0);
            end
            if (!busy_a && !busy_b && !busy_c) done = 1'b1;
            step();
        end
        if (!done) chk("init_timeout", 32'h0, 32'h1);
        wr1_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, nc;
        vec_t e;
        logic [31:0] expc [24];

        v[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0, 1'b0};
        v[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        v[2]  = '{1'b1, 5'd7, 32'h1111,     1'b1, 5'd7, 32'h2222,     5'd7, 5'd5,  32'h2222,     32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        v[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd7,  32'h2222,     32'h2222,     32'h2222,     32'h2222,     1'b1, 1'b1};
        v[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0,  32'h2222,     32'h0,        32'h2222,     32'h0,        1'b0, 1'b0};
        v[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
        v[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[7]  = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       5'd3, 5'd4,  32'h11,       32'h22,       32'h0,        32'h0,        1'b0, 1'b0};
        v[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd4,  32'h11,       32'h22,       32'h11,       32'h22,       1'b0, 1'b0};
        v[9]  = '{1'b1, 5'd0, 32'h33,       1'b1, 5'd0, 32'h44,       5'd0, 5'd31, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0};
        v[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd31, 32'h0,        32'h0,        32'h44,       32'h0,        1'b0, 1'b1};
        v[11] = '{1'b1, 5'd8, 32'hAB,       1'b0, 5'd0, 32'h0,        5'd8, 5'd8,  32'hAB,       32'hAB,       32'h0,        32'h0,        1'b0, 1'b0};

        for (int i = 0; i < 24; i++) expc[i] = 32'h0;
        expc[3] = 32'h11;
        expc[4] = 32'h22;
        expc[5] = 32'hDEADBEEF;
        expc[7] = 32'h2222;
        expc[8] = 32'hAB;

        // Reset for one clock edge, then the clear sequence with wr1 attempts.
        idle();
        rd_addr = 10'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_init(1'b1, na, nb, nc);
        chk("busy_cycles_a", 32'(na), 32'd32);
        chk("busy_cycles_b", 32'(nb), 32'd32);
        chk("busy_cycles_c", 32'(nc), 32'd24);

        // Every register reads zero after the clear (x9 included).
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'(31 - i), 5'(i)};
            #4;
            chk("clr_a0", rd_a[31:0],  32'h0);
            chk("clr_a1", rd_a[63:32], 32'h0);
            chk("clr_b0", rd_b[31:0],  32'h0);
            chk("clr_b1", rd_b[63:32], 32'h0);
            chk("clr_c0", rd_c[31:0],  32'h0);
            chk("clr_c1", rd_c[63:32], 32'h0);
            step();
        end

        // Table of READY-state vectors; dut_c shares dut_a's expectations.
        for (int i = 0; i < NV; i++) begin
            wr0_en = v[i].w0e; wr0_addr = v[i].w0a; wr0_data = v[i].w0d;
            wr1_en = v[i].w1e; wr1_addr = v[i].w1a; wr1_data = v[i].w1d;
            rd_addr = {v[i].r1, v[i].r0};
            sb.push_back(v[i]);
            #4;
            e = sb.pop_front();
            chk($sformatf("vec%0d_a0", i), rd_a[31:0],  e.ea0);
            chk($sformatf("vec%0d_a1", i), rd_a[63:32], e.ea1);
            chk($sformatf("vec%0d_b0", i), rd_b[31:0],  e.eb0);
            chk($sformatf("vec%0d_b1", i), rd_b[63:32], e.eb1);
            chk($sformatf("vec%0d_c0", i), rd_c[31:0],  e.ea0);
            chk($sformatf("vec%0d_c1", i), rd_c[63:32], e.ea1);
            chk($sformatf("vec%0d_conf_a", i), 32'(conf_a), 32'(e.eca));
            chk($sformatf("vec%0d_conf_b", i), 32'(conf_b), 32'(e.ecb));
            chk($sformatf("vec%0d_conf_c", i), 32'(conf_c), 32'(e.eca));
            step();
        end
        idle();

        // Out-of-range write on the 24-entry instance.
        wr0_en = 1'b1; wr0_addr = 5'd30; wr0_data = 32'h55;
        rd_addr = {5'd30, 5'd30};
        #4;
        chk("oor_same_c0", rd_c[31:0], 32'h0);
        step();
        idle();
        #4;
        chk("oor_next_c0", rd_c[31:0], 32'h0);
        step();
        for (int i = 0; i < 24; i++) begin
            rd_addr = {5'(i), 5'(i)};
            #4;
            chk($sformatf("keep_c_x%0d", i), rd_c[31:0], expc[i]);
            step();
        end

        // Write x3, then reset again and interrupt the clear at cycle 10.
        wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA5;
        step();
        idle();
        rd_addr = {5'd3, 5'd3};
        #4;
        chk("x3_written_a", rd_a[31:0], 32'hA5);
        chk("x3_written_b", rd_b[31:0], 32'hA5);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #4;
            chk("mid_busy_a", 32'(busy_a), 32'h1);
            chk("mid_rd_a", rd_a[31:0], 32'h0);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_init(1'b0, na, nb, nc);
        chk("rebusy_cycles_a", 32'(na), 32'd32);
        chk("rebusy_cycles_b", 32'(nb), 32'd32);
        chk("rebusy_cycles_c", 32'(nc), 32'd24);
        rd_addr = {5'd3, 5'd3};
        #4;
        chk("x3_cleared_a", rd_a[31:0], 32'h0);
        chk("x3_cleared_b", rd_b[31:0], 32'h0);
        chk("x3_cleared_c", rd_c[31:0], 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
